l2t_sii_iq_rcv: RTL and testbench

L2T_SII_IQ_RCV -- requirements
Module: l2t_sii_iq_rcv

---
 rtl/sii_l2t_pkg.sv | 18 +
 rtl/l2t_sii_iq_fifo.sv | 59 +++++
 rtl/l2t_sii_iq_rcv.sv | 156 +++++++++++++++
 tb/tb_l2t_sii_iq_rcv.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sii_l2t_pkg.sv
// Shared definitions for the SII-to-L2T input-queue receiver: capture FSM
// states, header field positions and default queue geometry.
package sii_l2t_pkg;

    localparam int IQ_DEPTH_DEFAULT   = 4;
    localparam int DATA_WORDS_DEFAULT = 16;
    localparam int WORD_W             = 32;
    localparam int HDR_W              = 64;
    localparam int HDR_WR_BIT         = 63;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA
    } cap_state_e;

endpackage

// File: rtl/l2t_sii_iq_fifo.sv
// Input-queue storage: circular buffer with head/tail pointers and an
// occupancy count that tells full from empty when the pointers coincide.
module l2t_sii_iq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign full    = (cnt == CW'(DEPTH));
    assign do_rd   = rd_en && (cnt != '0);
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Entry storage is deliberately left without reset; the head is masked upstream when empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/l2t_sii_iq_rcv.sv
// SII-to-L2T request receiver: captures header/data beats from the SII bus,
// queues complete requests and returns one credit per entry popped by L2T.
module l2t_sii_iq_rcv
    import sii_l2t_pkg::*;
#(
    parameter int IQ_DEPTH   = IQ_DEPTH_DEFAULT,
    parameter int DATA_WORDS = DATA_WORDS_DEFAULT
) (
    input  logic                         iol2clk,
    input  logic                         rst_l,
    input  logic                         sii_l2t_req_vld,
    input  logic [31:0]                  sii_l2t_req,
    output logic                         l2t_sii_iq_dequeue,
    output logic                         iq_vld,
    output logic [63:0]                  iq_hdr,
    output logic [32*DATA_WORDS-1:0]     iq_data,
    input  logic                         iq_rd,
    output logic [$clog2(IQ_DEPTH):0]    iq_cnt,
    output logic                         iq_err
);

    localparam int DW  = WORD_W * DATA_WORDS;
    localparam int EW  = HDR_W + DW;
    localparam int WCW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(DATA_WORDS - 1);

    cap_state_e       state;
    cap_state_e       next_state;
    logic [HDR_W-1:0] cap_hdr;
    logic [DW-1:0]    cap_data;
    logic [WCW-1:0]   word_cnt;
    logic             commit_q;
    logic             restart;
    logic             proto_err;
    logic             cap_hi;
    logic             cap_lo;
    logic             cap_word;
    logic             commit_set;
    logic             pop;
    logic             full;
    logic             overflow;
    logic [EW-1:0]    head_entry;

    // Capture FSM state register.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and beat-capture strobes; a new request start always wins and abandons any partial capture.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        proto_err  = 1'b0;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        cap_word   = 1'b0;
        commit_set = 1'b0;
        if (sii_l2t_req_vld) begin
            next_state = ST_HDR_HI;
            restart    = 1'b1;
            proto_err  = (state != ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_IDLE;
                end
                ST_HDR_HI: begin
                    cap_hi     = 1'b1;
                    next_state = ST_HDR_LO;
                end
                ST_HDR_LO: begin
                    cap_lo = 1'b1;
                    if (cap_hdr[HDR_WR_BIT]) begin
                        next_state = ST_DATA;
                    end else begin
                        next_state = ST_IDLE;
                        commit_set = 1'b1;
                    end
                end
                ST_DATA: begin
                    cap_word = 1'b1;
                    if (word_cnt == LAST_WORD) begin
                        next_state = ST_IDLE;
                        commit_set = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Staging registers for the request being assembled; data is cleared at each start so reads carry zero data.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            cap_hdr  <= '0;
            cap_data <= '0;
            word_cnt <= '0;
            commit_q <= 1'b0;
        end else begin
            commit_q <= commit_set;
            if (restart) begin
                cap_data <= '0;
                word_cnt <= '0;
            end
            if (cap_hi) begin
                cap_hdr[63:32] <= sii_l2t_req;
            end
            if (cap_lo) begin
                cap_hdr[31:0] <= sii_l2t_req;
            end
            if (cap_word) begin
                cap_data[word_cnt*WORD_W +: WORD_W] <= sii_l2t_req;
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

    assign pop      = iq_rd && iq_vld;
    assign overflow = commit_q && full && !pop;

    l2t_sii_iq_fifo #(
        .DEPTH (IQ_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (iol2clk),
        .rst_n   (rst_l),
        .wr_en   (commit_q),
        .wr_data ({cap_hdr, cap_data}),
        .rd_en   (pop),
        .rd_data (head_entry),
        .cnt     (iq_cnt),
        .full    (full)
    );

    assign iq_vld  = (iq_cnt != '0);
    assign iq_hdr  = iq_vld ? head_entry[EW-1:DW] : '0;
    assign iq_data = iq_vld ? head_entry[DW-1:0]  : '0;

    // Credit return one cycle after each pop, plus the sticky error flag.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            l2t_sii_iq_dequeue <= 1'b0;
            iq_err             <= 1'b0;
        end else begin
            l2t_sii_iq_dequeue <= pop;
            iq_err             <= iq_err || proto_err || overflow || (iq_rd && !iq_vld);
        end
    end

endmodule

// File: tb/tb_l2t_sii_iq_rcv.sv
// Directed self-checking bench for l2t_sii_iq_rcv with an expected-entry scoreboard.
module tb_l2t_sii_iq_rcv;

    typedef struct packed {
        logic [63:0]  hdr;
        logic [511:0] data;
    } entry_t;

    logic         iol2clk = 1'b0;
    logic         rst_l   = 1'b0;
    logic         sii_l2t_req_vld = 1'b0;
    logic [31:0]  sii_l2t_req = '0;
    logic         l2t_sii_iq_dequeue;
    logic         iq_vld;
    logic [63:0]  iq_hdr;
    logic [511:0] iq_data;
    logic         iq_rd = 1'b0;
    logic [2:0]   iq_cnt;
    logic         iq_err;

    int     errors = 0;
    int     checks = 0;
    entry_t sb[$];

    l2t_sii_iq_rcv #(.IQ_DEPTH(4), .DATA_WORDS(16)) dut (
        .iol2clk            (iol2clk),
        .rst_l              (rst_l),
        .sii_l2t_req_vld    (sii_l2t_req_vld),
        .sii_l2t_req        (sii_l2t_req),
        .l2t_sii_iq_dequeue (l2t_sii_iq_dequeue),
        .iq_vld             (iq_vld),
        .iq_hdr             (iq_hdr),
        .iq_data            (iq_data),
        .iq_rd              (iq_rd),
        .iq_cnt             (iq_cnt),
        .iq_err             (iq_err)
    );

    always #5 iol2clk = ~iol2clk;

    task automatic tick();
        @(posedge iol2clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [575:0] observed, input logic [575:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one request: vld beat, two header beats, then nwords data beats; returns just before the commit edge.
    task automatic applyStimulus(input logic [63:0] hdr, input logic [511:0] data, input int nwords);
        sii_l2t_req_vld = 1'b1;
        sii_l2t_req     = 32'hDEAD_BEEF;
        tick();
        sii_l2t_req_vld = 1'b0;
        sii_l2t_req     = hdr[63:32];
        tick();
        sii_l2t_req     = hdr[31:0];
        tick();
        for (int i = 0; i < nwords; i++) begin
            sii_l2t_req = data[i*32 +: 32];
            tick();
        end
        sii_l2t_req = '0;
    endtask

    task automatic doReset();
        rst_l = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
        sb.delete();
    endtask

    task automatic popAndCheck(input string tag);
        entry_t exp;
        exp = sb.pop_front();
        checkOutput({tag, "_vld"},  576'(iq_vld), 576'(1'b1));
        checkOutput({tag, "_hdr"},  576'(iq_hdr), 576'(exp.hdr));
        checkOutput({tag, "_data"}, 576'(iq_data), 576'(exp.data));
        iq_rd = 1'b1;
        tick();
        iq_rd = 1'b0;
        checkOutput({tag, "_deq"}, 576'(l2t_sii_iq_dequeue), 576'(1'b1));
        tick();
        checkOutput({tag, "_deq_once"}, 576'(l2t_sii_iq_dequeue), 576'(1'b0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [511:0] wdata;
        logic [511:0] zero_data;
        zero_data = '0;
        for (int i = 0; i < 16; i++) begin
            wdata[i*32 +: 32] = 32'h100 + 32'(i);
        end

        // Reset state
        tick();
        checkOutput("rst_vld",  576'(iq_vld), 576'(1'b0));
        checkOutput("rst_cnt",  576'(iq_cnt), 576'(3'd0));
        checkOutput("rst_err",  576'(iq_err), 576'(1'b0));
        checkOutput("rst_deq",  576'(l2t_sii_iq_dequeue), 576'(1'b0));
        checkOutput("rst_hdr",  576'(iq_hdr), 576'(64'd0));
        checkOutput("rst_data", 576'(iq_data), 576'(zero_data));
        doReset();

        // Single read: latency t+4, then pop
        $display("[TB] read request");
        applyStimulus(64'h0000_1234_89AB_CDEF, zero_data, 0);
        sb.push_back('{hdr: 64'h0000_1234_89AB_CDEF, data: zero_data});
        checkOutput("rd_vld_t3", 576'(iq_vld), 576'(1'b0));
        tick();
        checkOutput("rd_vld_t4", 576'(iq_vld), 576'(1'b1));
        checkOutput("rd_cnt1",   576'(iq_cnt), 576'(3'd1));
        popAndCheck("rd");
        checkOutput("rd_cnt0", 576'(iq_cnt), 576'(3'd0));
        checkOutput("rd_err",  576'(iq_err), 576'(1'b0));

        // Write with 16 data words
        $display("[TB] write request");
        applyStimulus(64'h8000_0000_0000_0040, wdata, 16);
        sb.push_back('{hdr: 64'h8000_0000_0000_0040, data: wdata});
        checkOutput("wr_vld_pre", 576'(iq_vld), 576'(1'b0));
        tick();
        popAndCheck("wr");

        // iq_rd while empty is ignored but flagged
        iq_rd = 1'b1;
        tick();
        iq_rd = 1'b0;
        checkOutput("empty_rd_err", 576'(iq_err), 576'(1'b1));
        checkOutput("empty_rd_cnt", 576'(iq_cnt), 576'(3'd0));
        tick();
        checkOutput("empty_rd_deq", 576'(l2t_sii_iq_dequeue), 576'(1'b0));
        doReset();
        checkOutput("rst2_err", 576'(iq_err), 576'(1'b0));

        // Fill to depth, then overflow
        $display("[TB] fill and overflow");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(64'h0000_0000_0000_0A00 + 64'(i), zero_data, 0);
            sb.push_back('{hdr: 64'h0000_0000_0000_0A00 + 64'(i), data: zero_data});
            tick();
        end
        checkOutput("fill_cnt", 576'(iq_cnt), 576'(3'd4));
        checkOutput("fill_err", 576'(iq_err), 576'(1'b0));
        applyStimulus(64'h0000_0000_0000_0BAD, zero_data, 0);
        tick();
        checkOutput("ovf_err",  576'(iq_err), 576'(1'b1));
        checkOutput("ovf_cnt",  576'(iq_cnt), 576'(3'd4));
        checkOutput("ovf_head", 576'(iq_hdr), 576'(sb[0].hdr));

        // Commit and pop in the same cycle while full
        $display("[TB] commit with pop while full");
        applyStimulus(64'h0000_0000_0000_0C00, zero_data, 0);
        sb.push_back('{hdr: 64'h0000_0000_0000_0C00, data: zero_data});
        checkOutput("cp_head", 576'(iq_hdr), 576'(sb[0].hdr));
        void'(sb.pop_front());
        iq_rd = 1'b1;
        tick();
        iq_rd = 1'b0;
        checkOutput("cp_cnt", 576'(iq_cnt), 576'(3'd4));
        checkOutput("cp_deq", 576'(l2t_sii_iq_dequeue), 576'(1'b1));
        tick();
        checkOutput("cp_deq_once", 576'(l2t_sii_iq_dequeue), 576'(1'b0));
        for (int i = 0; i < 4; i++) begin
            popAndCheck($sformatf("drain%0d", i));
        end
        checkOutput("drain_cnt", 576'(iq_cnt), 576'(3'd0));
        doReset();

        // New request start in the middle of a write's data phase
        $display("[TB] abort during data");
        applyStimulus(64'h8000_0000_0000_00AA, wdata, 5);
        applyStimulus(64'h8000_0000_5555_0001, ~wdata, 16);
        sb.push_back('{hdr: 64'h8000_0000_5555_0001, data: ~wdata});
        checkOutput("abort_err", 576'(iq_err), 576'(1'b1));
        checkOutput("abort_cnt", 576'(iq_cnt), 576'(3'd0));
        tick();
        checkOutput("abort_cnt1", 576'(iq_cnt), 576'(3'd1));
        popAndCheck("abort");
        doReset();

        // Reset asserted mid-header with two entries queued
        $display("[TB] reset during capture");
        for (int i = 0; i < 2; i++) begin
            applyStimulus(64'h0000_0000_0000_0D00 + 64'(i), zero_data, 0);
            tick();
        end
        checkOutput("pre_rst_cnt", 576'(iq_cnt), 576'(3'd2));
        sii_l2t_req_vld = 1'b1;
        tick();
        sii_l2t_req_vld = 1'b0;
        sii_l2t_req     = 32'h0000_0077;
        tick();
        sii_l2t_req     = 32'h0000_0088;
        #2;
        rst_l = 1'b0;
        #1;
        checkOutput("mid_rst_vld", 576'(iq_vld), 576'(1'b0));
        checkOutput("mid_rst_cnt", 576'(iq_cnt), 576'(3'd0));
        checkOutput("mid_rst_deq", 576'(l2t_sii_iq_dequeue), 576'(1'b0));
        checkOutput("mid_rst_hdr", 576'(iq_hdr), 576'(64'd0));
        tick();
        checkOutput("mid_rst_deq2", 576'(l2t_sii_iq_dequeue), 576'(1'b0));
        sii_l2t_req = '0;
        rst_l = 1'b1;
        sb.delete();
        tick();
        checkOutput("post_rst_vld", 576'(iq_vld), 576'(1'b0));
        applyStimulus(64'h0000_0000_0000_0E01, zero_data, 0);
        sb.push_back('{hdr: 64'h0000_0000_0000_0E01, data: zero_data});
        tick();
        checkOutput("post_rst_cnt", 576'(iq_cnt), 576'(3'd1));
        popAndCheck("post_rst");
        checkOutput("post_rst_err", 576'(iq_err), 576'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
